// File: rtl/uart_rx_packetizer.sv
// Assembles SYNC + payload + XOR-checksum packets from a UART receiver byte stream
// and presents verified packets on a single-entry valid/ready output buffer.
module uart_rx_packetizer #(
   parameter int unsigned PAYLOAD_BYTES  = 4,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
   input  logic                         clock_i,
   input  logic                         reset_n_i,
   input  logic [7:0]                   rx_data_i,
   input  logic                         rx_done_i,
   input  logic                         rx_framing_error_i,
   output logic [8*PAYLOAD_BYTES-1:0]   pkt_data_o,
   output logic                         pkt_valid_o,
   input  logic                         pkt_ready_i,
   output logic                         busy_o,
   output logic                         err_checksum_o,
   output logic                         err_framing_o,
   output logic                         err_timeout_o,
   output logic                         err_overflow_o
);

   localparam int IW = $clog2(PAYLOAD_BYTES) + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_t;

   state_t                       state_q;
   logic [IW-1:0]                idx_q;
   logic [7:0]                   acc_q;
   logic [TW-1:0]                timer_q;
   logic                         fe_q;
   logic [8*PAYLOAD_BYTES-1:0]   asm_flat;

   logic fe_rise;
   logic byte_ok;
   logic good_pkt;
   logic accept;
   logic timed_out;

   // A framing-error rising edge swallows any byte that arrives in the same cycle.
   assign fe_rise   = rx_framing_error_i & ~fe_q;
   assign byte_ok   = rx_done_i & ~fe_rise;
   assign good_pkt  = byte_ok && (state_q == CHECK) && (rx_data_i == acc_q);
   assign accept    = pkt_valid_o & pkt_ready_i;
   assign timed_out = (state_q != HUNT) && !rx_done_i && (timer_q == TW'(TIMEOUT_CYCLES - 1));
   assign busy_o    = (state_q != HUNT);

   for (genvar gi = 0; gi < PAYLOAD_BYTES; gi++) begin : g_slot
      logic [7:0] slot_q;
      always_ff @(posedge clock_i) begin
         if (!reset_n_i) begin
            slot_q <= '0;
         end else if (byte_ok && (state_q == PAYLOAD) && (idx_q == IW'(gi))) begin
            slot_q <= rx_data_i;
         end
      end
      assign asm_flat[gi*8 +: 8] = slot_q;
   end

   always_ff @(posedge clock_i) begin
      if (!reset_n_i) begin
         state_q        <= HUNT;
         idx_q          <= '0;
         acc_q          <= '0;
         timer_q        <= '0;
         fe_q           <= 1'b0;
         pkt_data_o     <= '0;
         pkt_valid_o    <= 1'b0;
         err_checksum_o <= 1'b0;
         err_framing_o  <= 1'b0;
         err_timeout_o  <= 1'b0;
         err_overflow_o <= 1'b0;
      end else begin
         fe_q           <= rx_framing_error_i;
         err_checksum_o <= 1'b0;
         err_framing_o  <= fe_rise;
         err_timeout_o  <= 1'b0;
         err_overflow_o <= 1'b0;
         timer_q        <= ((state_q == HUNT) || rx_done_i) ? '0 : timer_q + TW'(1);

         if (fe_rise) begin
            state_q <= HUNT;
         end else if (byte_ok) begin
            case (state_q)
               HUNT: begin
                  if (rx_data_i == SYNC_BYTE) begin
                     state_q <= PAYLOAD;
                     idx_q   <= '0;
                     acc_q   <= '0;
                  end
               end
               PAYLOAD: begin
                  acc_q <= acc_q ^ rx_data_i;
                  idx_q <= idx_q + IW'(1);
                  if (idx_q == IW'(PAYLOAD_BYTES - 1)) state_q <= CHECK;
               end
               CHECK: begin
                  state_q <= HUNT;
                  if (rx_data_i != acc_q) err_checksum_o <= 1'b1;
               end
               default: state_q <= HUNT;
            endcase
         end else if (timed_out) begin
            state_q       <= HUNT;
            err_timeout_o <= 1'b1;
         end

         // A full buffer can still take a new packet if it is being drained this cycle.
         if (good_pkt) begin
            if (!pkt_valid_o || accept) begin
               pkt_data_o  <= asm_flat;
               pkt_valid_o <= 1'b1;
            end else begin
               err_overflow_o <= 1'b1;
            end
         end else if (accept) begin
            pkt_valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_packetizer.sv
// Directed bench for uart_rx_packetizer (2-byte payload, SYNC A5, 50-cycle timeout)
// with a queue-based packet model compared against the DUT every cycle.
module tb_uart_rx_packetizer;

   localparam int P  = 2;
   localparam int TO = 50;

   logic        clk;
   logic        rst_n;
   logic [7:0]  rx_data;
   logic        rx_done;
   logic        rx_fe;
   logic [15:0] pkt_data;
   logic        pkt_valid;
   logic        pkt_ready;
   logic        busy;
   logic        err_ck, err_fr, err_to, err_ov;

   uart_rx_packetizer #(
      .PAYLOAD_BYTES (P),
      .SYNC_BYTE     (8'hA5),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clock_i           (clk),
      .reset_n_i         (rst_n),
      .rx_data_i         (rx_data),
      .rx_done_i         (rx_done),
      .rx_framing_error_i(rx_fe),
      .pkt_data_o        (pkt_data),
      .pkt_valid_o       (pkt_valid),
      .pkt_ready_i       (pkt_ready),
      .busy_o            (busy),
      .err_checksum_o    (err_ck),
      .err_framing_o     (err_fr),
      .err_timeout_o     (err_to),
      .err_overflow_o    (err_ov)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // ---------------- packet model ----------------
   bit          started = 1'b0;
   bit          in_pkt, fe_prev, buf_v, e_ck, e_fr, e_to, e_ov;
   bit          rise, accept_m, good;
   int          gap;
   logic [7:0]  got[$];
   logic [7:0]  x;
   logic [15:0] buf_d;

   initial forever begin
      @(posedge clk);
      if (!rst_n) begin
         in_pkt = 0; got.delete(); gap = 0; fe_prev = 0;
         buf_d = '0; buf_v = 0; e_ck = 0; e_fr = 0; e_to = 0; e_ov = 0;
         started = 1;
      end else begin
         rise     = rx_fe && !fe_prev;
         fe_prev  = rx_fe;
         accept_m = buf_v && pkt_ready;
         good = 0; e_ck = 0; e_fr = 0; e_to = 0; e_ov = 0;
         if (rise) begin
            e_fr = 1;
            in_pkt = 0;
         end else if (rx_done) begin
            if (!in_pkt) begin
               if (rx_data == 8'hA5) begin
                  in_pkt = 1; got.delete(); gap = 0;
               end
            end else begin
               gap = 0;
               if (got.size() < P) got.push_back(rx_data);
               else begin
                  x = 8'h00;
                  foreach (got[i]) x ^= got[i];
                  if (x == rx_data) good = 1; else e_ck = 1;
                  in_pkt = 0;
               end
            end
         end else if (in_pkt) begin
            gap++;
            if (gap == TO) begin
               in_pkt = 0;
               e_to = 1;
            end
         end
         if (good) begin
            if (!buf_v || accept_m) begin
               buf_d = {got[1], got[0]};
               buf_v = 1;
            end else e_ov = 1;
         end else if (accept_m) buf_v = 0;
      end
   end

   // ---------------- acceptance capture (pre-edge values) ----------------
   int          acc_n = 0;
   logic [15:0] last_acc = '0;
   initial forever begin
      @(posedge clk);
      if (rst_n && pkt_valid === 1'b1 && pkt_ready === 1'b1) begin
         acc_n++;
         last_acc = pkt_data;
      end
   end

   // ---------------- per-cycle compare and pulse counting ----------------
   int ncyc = 0;
   int cnt_ck = 0, cnt_fr = 0, cnt_to = 0, cnt_ov = 0;
   int to_cyc = 0;
   initial forever begin
      @(negedge clk);
      ncyc++;
      if (started) begin
         chk("cycle", {10'b0, busy, pkt_valid, err_ck, err_fr, err_to, err_ov, pkt_data},
                      {10'b0, in_pkt, buf_v, e_ck, e_fr, e_to, e_ov, buf_d});
         if (err_ck === 1'b1) cnt_ck++;
         if (err_fr === 1'b1) cnt_fr++;
         if (err_ov === 1'b1) cnt_ov++;
         if (err_to === 1'b1) begin
            cnt_to++;
            to_cyc = ncyc;
         end
      end
   end

   // ---------------- stimulus ----------------
   int t_done;
   int s_acc, s_ck, s_fr, s_to, s_ov;

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      tick();
      rx_data = b;
      rx_done = 1'b1;
      t_done  = ncyc;
      tick();
      rx_done = 1'b0;
      tick();
      tick();
   endtask

   task automatic snap();
      s_acc = acc_n; s_ck = cnt_ck; s_fr = cnt_fr; s_to = cnt_to; s_ov = cnt_ov;
   endtask

   initial begin
      rst_n = 1'b0; rx_data = 8'h00; rx_done = 1'b0; rx_fe = 1'b0; pkt_ready = 1'b0;
      repeat (3) tick();
      chk("reset_valid", {31'b0, pkt_valid}, 32'd0);
      chk("reset_busy",  {31'b0, busy}, 32'd0);
      chk("reset_data",  {16'b0, pkt_data}, 32'd0);
      rst_n = 1'b1;
      tick();

      // good packet, consumer ready
      pkt_ready = 1'b1;
      snap();
      send(8'hA5); send(8'h12); send(8'h34); send(8'h26);
      chk("t1_delivered", acc_n - s_acc, 1);
      chk("t1_data", {16'b0, last_acc}, 32'h3412);
      chk("t1_no_errors", (cnt_ck - s_ck) + (cnt_ov - s_ov) + (cnt_to - s_to) + (cnt_fr - s_fr), 0);
      chk("t1_busy", {31'b0, busy}, 32'd0);

      // bad checksum, then a good packet
      snap();
      send(8'hA5); send(8'h12); send(8'h34); send(8'h27);
      chk("t2_ck_pulse", cnt_ck - s_ck, 1);
      chk("t2_no_delivery", acc_n - s_acc, 0);
      chk("t2_valid", {31'b0, pkt_valid}, 32'd0);
      send(8'hA5); send(8'h01); send(8'h02); send(8'h03);
      chk("t2_delivered", acc_n - s_acc, 1);
      chk("t2_data", {16'b0, last_acc}, 32'h0201);

      // junk before sync, then overflow while the buffer is held
      pkt_ready = 1'b0;
      snap();
      send(8'h00); send(8'hFF); send(8'hA5); send(8'hAA); send(8'h55); send(8'hFF);
      chk("t3_held_valid", {31'b0, pkt_valid}, 32'd1);
      chk("t3_held_data", {16'b0, pkt_data}, 32'h55AA);
      send(8'hA5); send(8'hAA); send(8'h55); send(8'hFF);
      chk("t3_overflow", cnt_ov - s_ov, 1);
      chk("t3_still_valid", {31'b0, pkt_valid}, 32'd1);
      chk("t3_still_data", {16'b0, pkt_data}, 32'h55AA);
      pkt_ready = 1'b1;
      tick(); tick();
      chk("t3_drained", acc_n - s_acc, 1);
      chk("t3_drained_data", {16'b0, last_acc}, 32'h55AA);
      chk("t3_valid_low", {31'b0, pkt_valid}, 32'd0);

      // inter-byte timeout
      snap();
      send(8'hA5); send(8'h12);
      repeat (58) tick();
      chk("t4_to_pulse", cnt_to - s_to, 1);
      chk("t4_to_cycle", to_cyc - t_done, 51);
      chk("t4_busy", {31'b0, busy}, 32'd0);
      send(8'h34); send(8'h26);
      chk("t4_late_ignored", acc_n - s_acc, 0);
      chk("t4_no_ck", cnt_ck - s_ck, 0);

      // framing error rising together with a byte
      snap();
      send(8'hA5); send(8'h12);
      tick();
      rx_fe = 1'b1; rx_data = 8'h34; rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
      repeat (99) tick();
      rx_fe = 1'b0;
      tick();
      chk("t5_fr_pulse", cnt_fr - s_fr, 1);
      chk("t5_busy", {31'b0, busy}, 32'd0);
      chk("t5_no_ck", cnt_ck - s_ck, 0);

      // reset mid-packet
      send(8'hA5); send(8'h12);
      chk("t6_busy_before", {31'b0, busy}, 32'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("t6_valid", {31'b0, pkt_valid}, 32'd0);
      chk("t6_busy", {31'b0, busy}, 32'd0);
      chk("t6_data", {16'b0, pkt_data}, 32'd0);
      snap();
      send(8'hA5); send(8'h12); send(8'h34); send(8'h26);
      chk("t6_delivered", acc_n - s_acc, 1);
      chk("t6_data_after", {16'b0, last_acc}, 32'h3412);

      repeat (3) tick();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_packetizer.md
Name: uart_rx_packetizer

Overview:
- Sits directly downstream of the UART receiver. Consumes its byte stream (data byte, one-cycle done pulse, framing-error level) and assembles fixed-length command packets: SYNC byte, PAYLOAD_BYTES payload bytes, then an XOR checksum byte.
- Presents each verified packet on a single-entry valid/ready output buffer to the command decoder.
- Reports checksum, framing, timeout and overflow faults as one-cycle pulses.

Parameters:
- PAYLOAD_BYTES, 4, number of payload bytes per packet (1..16).
- SYNC_BYTE, 8'hA5, header byte that starts a packet.
- TIMEOUT_CYCLES, 100_000, maximum clock cycles allowed between consecutive bytes inside a packet (about 4 byte-times at 25 MHz / 9600 baud).

Ports:
- clock  input  1  system clock.
- reset_n  input  1  one clock; reset is synchronous and active-low.
- rx_data  input  8  byte from the UART receiver; valid only in the cycle rx_done=1.
- rx_done  input  1  one-cycle pulse per received byte.
- rx_framing_error  input  1  level; high while the receiver is in its framing-error state.
- pkt_data  output  8*PAYLOAD_BYTES  payload; first received byte in [7:0].
- pkt_valid  output  1  output buffer holds an unread packet.
- pkt_ready  input  1  consumer accepts the packet when pkt_valid && pkt_ready.
- busy  output  1  high in any state other than HUNT.
- err_checksum  output  1  one-cycle pulse: checksum mismatch, packet dropped.
- err_framing  output  1  one-cycle pulse: rising edge of rx_framing_error seen.
- err_timeout  output  1  one-cycle pulse: inter-byte gap exceeded inside a packet.
- err_overflow  output  1  one-cycle pulse: good packet dropped because the buffer was still full.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - All outputs go to 0, pkt_data goes to 0, state goes to HUNT, and all counters and the checksum accumulator clear.
  - Reset applied mid-packet or with pkt_valid=1 discards everything.
- FSM states: HUNT, PAYLOAD, CHECK.
  - HUNT: on rx_done with rx_data==SYNC_BYTE, go to PAYLOAD and clear the byte index, accumulator and timer. Any other byte is ignored.
  - PAYLOAD: on each rx_done, write rx_data into assembly-register slot [index], XOR it into the accumulator, and increment the index. The byte with index == PAYLOAD_BYTES-1 moves the FSM to CHECK.
  - CHECK: on rx_done, compare rx_data to the accumulator, then return to HUNT.
    - On a match, the packet is good.
    - On a mismatch, pulse err_checksum in the next cycle.
- SYNC_BYTE appearing inside the payload or checksum is treated as data. There is no resynchronisation mid-packet.
- Accumulator is the XOR of payload bytes only; SYNC is excluded. Index width is clog2(PAYLOAD_BYTES)+1, with no wrap.
- Good-packet delivery:
  - The assembly register is separate from the output buffer.
  - On a good packet, if pkt_valid==0, or pkt_valid && pkt_ready in the same cycle, load pkt_data and hold pkt_valid=1 from the next cycle.
  - Otherwise, pkt_data and pkt_valid are unchanged, and err_overflow pulses in the next cycle.
- Handshake:
  - pkt_data is stable while pkt_valid=1.
  - pkt_valid drops in the cycle after acceptance, unless a new packet loads in that same cycle.
  - pkt_ready is ignored when pkt_valid=0.
- Timeout:
  - The timer clears on every rx_done and increments every cycle in PAYLOAD and CHECK.
  - When it reaches TIMEOUT_CYCLES-1 with no rx_done, go to HUNT and pulse err_timeout in the next cycle. The partial packet is discarded.
- Framing:
  - The block registers rx_framing_error and detects its rising edge. Each rising edge pulses err_framing in the next cycle, in any state.
  - If the FSM is not in HUNT, it also aborts to HUNT.
  - If the rising edge and rx_done occur in the same cycle, the framing error wins and the byte is ignored.
  - A level held high does not re-pulse.
- Pulse outputs are registered, high for exactly one cycle per event, and never blocked by pkt_valid.
- busy is a registered or decoded state: (state != HUNT).

Test Plan (PAYLOAD_BYTES=2, SYNC_BYTE=A5, TIMEOUT_CYCLES=50):
- Bytes A5,12,34,26 with pkt_ready=1 -> pkt_valid pulses with pkt_data=16'h3412; no error pulses; busy low afterwards.
- Bytes A5,12,34,27 -> err_checksum one pulse; pkt_valid stays 0; a following A5,01,02,03 delivers pkt_data=16'h0201.
- Bytes 00,FF,A5,AA,55,FF, then A5,AA,55,FF, with pkt_ready=0 -> first packet held with pkt_data=16'h55AA; second packet gives err_overflow; buffer is unchanged until pkt_ready=1.
- Bytes A5,12, then a 60-cycle gap -> err_timeout at cycle 50 of the gap; busy falls; late bytes 34,26 are ignored until the next A5.
- Bytes A5,12, then rx_framing_error raised for 100 cycles together with an rx_done -> a single err_framing; FSM in HUNT; the rx_done byte is dropped.
- Bytes A5,12, then reset_n low for 1 cycle -> all outputs 0; a subsequent full packet A5,12,34,26 is delivered correctly.
